// File: rtl/shift_unit_pipe.sv
// rtl/shift_unit_pipe.sv - pipelined log shifter (SLL/SRL/SRA/ROR) with valid/ready and tag
// Optional rotate datapath: SHIFT_UNIT_ROTATE_EN (undefined: op 11 behaves as SRL)
module shift_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [$clog2(WIDTH):0] in_amt,
  input  logic [1:0]             in_op,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic                   r_valid [SHW];
  logic [WIDTH-1:0]       r_data  [SHW];
  logic [SHW-1:0]         r_amt   [SHW];
  logic [1:0]             r_op    [SHW];
  logic                   r_sign  [SHW];
  logic [TAG_W-1:0]       r_tag   [SHW];

  logic             w_stall;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_sat_data;
  logic             w_unused_bits;

  // One logarithmic level: shift/rotate by 2^k when en is set.
  function automatic logic [WIDTH-1:0] f_stage(input logic [WIDTH-1:0] d, input logic [1:0] op,
                                               input logic sign, input int k, input logic en);
    logic [2*WIDTH-1:0] w_wide;
    int                 sh;
    sh      = 1 << k;
    w_wide  = '0;
    f_stage = d;
    if (en) begin
      case (op)
        OP_SLL: f_stage = d << sh;
        OP_SRA: begin
          w_wide  = {{WIDTH{sign}}, d} >> sh;
          f_stage = w_wide[WIDTH-1:0];
        end
`ifdef SHIFT_UNIT_ROTATE_EN
        OP_ROR: begin
          w_wide  = {d, d} >> sh;
          f_stage = w_wide[WIDTH-1:0];
        end
`endif
        default: f_stage = d >> sh;
      endcase
    end
  endfunction

`ifdef SHIFT_UNIT_ROTATE_EN
  assign w_op = in_op;
`else
  assign w_op = (in_op == OP_ROR) ? OP_SRL : in_op;
`endif

  // Amounts >= WIDTH: rotate ignores the top bit, shifts collapse to fill value.
  always_comb begin
    w_sat_data = in_data;
    if (in_amt[SHW]) begin
      case (w_op)
        OP_SLL, OP_SRL: w_sat_data = '0;
        OP_SRA:         w_sat_data = {WIDTH{in_data[WIDTH-1]}};
        default:        w_sat_data = in_data;
      endcase
    end
  end

  assign w_stall   = r_valid[SHW-1] && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_valid[SHW-1];
  assign out_data  = r_data[SHW-1];
  assign out_tag   = r_tag[SHW-1];
  assign out_zero  = ~|r_data[SHW-1];

  assign w_unused_bits = ^{r_amt[SHW-1], r_op[SHW-1], r_sign[SHW-1]};

  // The whole pipe advances or holds together; bubbles are not squeezed out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SHW; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_amt[k]   <= '0;
        r_op[k]    <= '0;
        r_sign[k]  <= 1'b0;
        r_tag[k]   <= '0;
      end
    end else if (!w_stall) begin
      r_valid[0] <= in_valid;
      if (in_valid) begin
        r_data[0] <= f_stage(w_sat_data, w_op, in_data[WIDTH-1], 0, in_amt[0]);
        r_amt[0]  <= in_amt[SHW-1:0];
        r_op[0]   <= w_op;
        r_sign[0] <= in_data[WIDTH-1];
        r_tag[0]  <= in_tag;
      end
      for (int k = 1; k < SHW; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_data[k]  <= f_stage(r_data[k-1], r_op[k-1], r_sign[k-1], k, r_amt[k-1][k]);
        r_amt[k]   <= r_amt[k-1];
        r_op[k]    <= r_op[k-1];
        r_sign[k]  <= r_sign[k-1];
        r_tag[k]   <= r_tag[k-1];
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb/tb_shift_unit_pipe.sv - directed vector table plus stream, stall and reset sequences
module tb_shift_unit_pipe;

  localparam int W   = 8;
  localparam int TW  = 5;
  localparam int LAT = 3;

`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [7:0] E_ROR3 = 8'hD2, E_ROR9 = 8'h4B, E_ROR8 = 8'h96, E_ROR15 = 8'h2D;
`else
  localparam logic [7:0] E_ROR3 = 8'h12, E_ROR9 = 8'h00, E_ROR8 = 8'h00, E_ROR15 = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    in_amt;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_zero;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] amt;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  shift_unit_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input logic [3:0] amt, input logic [1:0] op);
    logic [1:0]        e;
    logic signed [7:0] sd;
    logic [15:0]       dd;
    e  = op;
    sd = d;
`ifndef SHIFT_UNIT_ROTATE_EN
    if (op == 2'b11) e = 2'b01;
`endif
    case (e)
      2'b00:   return (amt >= 8) ? 8'h00 : d << amt;
      2'b01:   return (amt >= 8) ? 8'h00 : d >> amt;
      2'b10:   return (amt >= 8) ? {8{d[7]}} : 8'(sd >>> amt);
      default: begin
        dd = {d, d} >> amt[2:0];
        return dd[7:0];
      end
    endcase
  endfunction

  task automatic add(input logic [1:0] op, input logic [3:0] amt, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.op = op; v.amt = amt; v.data = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic do_single(input string nm, input logic [1:0] op, input logic [3:0] amt,
                           input logic [7:0] d, input logic [4:0] tag, input logic [7:0] e);
    int n;
    in_valid = 1'b1; in_op = op; in_amt = amt; in_data = d; in_tag = tag;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h5A;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, LAT);
    chk({nm, "_data"}, out_data, e);
    chk({nm, "_tag"}, out_tag, tag);
    chk({nm, "_zero"}, out_zero, (e == 8'h00));
    @(posedge clk); #1;
  endtask

  // mode 0: out_ready always 1; mode 1: tags 1..6, out_ready low in cycles 4..8; mode 2: random
  task automatic run_stream(input string nm, input int n, input int mode, output int cycles);
    logic [12:0] sb[$];
    logic [12:0] e;
    logic [7:0]  d;
    logic [3:0]  a;
    logic [1:0]  o;
    logic [4:0]  t;
    int          issued, got, cyc, viol, saw_low, extra;
    bit          have;
    issued = 0; got = 0; cyc = 0; viol = 0; saw_low = 0; extra = 0; have = 0;
    d = '0; a = '0; o = '0; t = '0;
    while ((issued < n || got < n) && cyc < n * 4 + 50) begin
      cyc++;
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = !(cyc >= 4 && cyc <= 8);
      else                out_ready = 1'($urandom_range(0, 1));
      if (issued < n && !have) begin
        if (mode == 1) begin
          t = 5'(issued + 1); d = 8'(t * 8'h13); o = 2'b10; a = 4'(t);
        end else begin
          t = 5'(issued); d = 8'($urandom); o = 2'($urandom_range(0, 3)); a = 4'($urandom_range(0, 15));
        end
        have = 1;
      end
      in_valid = (issued < n);
      in_data = d; in_amt = a; in_op = o; in_tag = t;
      #1;
      if (in_ready !== !(out_valid && !out_ready)) viol++;
      if (!in_ready) saw_low = 1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk({nm, "_spurious_result"}, 1, 0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("%s_tag%0d", nm, got), out_tag, e[12:8]);
          chk($sformatf("%s_data%0d", nm, got), out_data, e[7:0]);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({t, model(d, a, o)});
        issued++;
        have = 0;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({nm, "_count"}, got, n);
    chk({nm, "_in_ready_rule"}, viol, 0);
    if (mode == 1) chk({nm, "_in_ready_dropped"}, saw_low, 1);
    repeat (6) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    chk({nm, "_no_duplicates"}, extra, 0);
    cycles = cyc;
  endtask

  initial begin
    int   cyc;
    int   stale;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_zero", out_zero, 1);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    add(2'b10, 4'd3,  8'h96, 8'hF2);
    add(2'b01, 4'd3,  8'h96, 8'h12);
    add(2'b00, 4'd3,  8'h96, 8'hB0);
    add(2'b11, 4'd3,  8'h96, E_ROR3);
    add(2'b11, 4'd9,  8'h96, E_ROR9);
    add(2'b00, 4'd9,  8'h96, 8'h00);
    add(2'b10, 4'd9,  8'h96, 8'hFF);
    add(2'b10, 4'd9,  8'h46, 8'h00);
    add(2'b01, 4'd9,  8'h96, 8'h00);
    add(2'b00, 4'd0,  8'h96, 8'h96);
    add(2'b01, 4'd0,  8'h96, 8'h96);
    add(2'b10, 4'd0,  8'h96, 8'h96);
    add(2'b11, 4'd0,  8'h96, 8'h96);
    add(2'b10, 4'd7,  8'h80, 8'hFF);
    add(2'b01, 4'd7,  8'h80, 8'h01);
    add(2'b00, 4'd7,  8'h01, 8'h80);
    add(2'b10, 4'd15, 8'h7F, 8'h00);
    add(2'b10, 4'd1,  8'h96, 8'hCB);
    add(2'b11, 4'd8,  8'h96, E_ROR8);
    add(2'b11, 4'd15, 8'h96, E_ROR15);

    for (int i = 0; i < vecs.size(); i++)
      do_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].data, 5'(i + 1), vecs[i].exp);

    run_stream("full_rate", 50, 0, cyc);
    chk("full_rate_cycles", cyc, 50 + LAT);
    run_stream("backpressure", 6, 1, cyc);

    // Reset while two operations are in flight
    in_valid = 1'b1; in_op = 2'b00; in_amt = 4'd1; in_data = 8'h01; in_tag = 5'd7;
    @(posedge clk); #1;
    in_data = 8'h02; in_tag = 5'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_zero", out_zero, 1);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    stale = 0;
    repeat (6) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    chk("midrst_no_stale", stale, 0);
    do_single("after_rst", 2'b01, 4'd2, 8'hF0, 5'd9, 8'h3C);

    run_stream("random", 1000, 2, cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
